mda_shutdown_controller: RTL
============================

# mda_shutdown_controller

Supervisory state machine that generates the `shutdown` input for the global GPIO disable stage. It synchronises and latches external fault lines, runs an optional software heartbeat watchdog, and re-enables outputs only after a software clear request plus a fault-free hold-off interval. It powers up in a safe, outputs-disabled state.

## Interface
- `NUM_FAULTS`, 2: number of external fault inputs.
- `HOLDOFF_CYCLES`, 1000: fault-free cycles required between an accepted clear and re-enable; must be ≥1.
- `WDT_CYCLES`, 50000000: watchdog timeout in clock cycles; must be ≥1.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fault_in`  in  NUM_FAULTS  asynchronous fault lines, active high.
- `heartbeat`  in  1  single-cycle software kick, synchronous to `clk`.
- `clear_req`  in  1  single-cycle software re-enable request, synchronous to `clk`.
- `shutdown`  out  1  registered; high = outputs forced to default.
- `fault_latched`  out  NUM_FAULTS  sticky record of faults seen since the last accepted clear.
- `wdt_tripped`  out  1  sticky watchdog-expiry flag.
- `state`  out  2  current state encoding.
- `clear_ack`  out  1  one-cycle pulse: re-enable completed.
- `clear_nack`  out  1  one-cycle pulse: clear rejected or hold-off aborted.

## Operation
- `fault_in` passes through a 2-flop synchroniser per bit; "fault" below means any synchronised bit high.
- States: SAFE=2'b00, RUN=2'b01, TRIPPED=2'b10, HOLDOFF=2'b11. `shutdown` = 0 only in RUN.
- SAFE / TRIPPED: `clear_req` with no fault → HOLDOFF, hold-off counter loaded with HOLDOFF_CYCLES-1, `fault_latched` and `wdt_tripped` cleared. `clear_req` with a fault → stay, `clear_nack` pulse. Fault and `clear_req` in the same cycle: fault wins.
- HOLDOFF: fault → TRIPPED, `clear_nack` pulse. Counter at 0 with no fault → RUN, `clear_ack` pulse, watchdog loaded with WDT_CYCLES-1. Otherwise decrement. `clear_req` is ignored.
- RUN: fault → TRIPPED. Watchdog at 0 and no `heartbeat` → TRIPPED, `wdt_tripped` set. `heartbeat` reloads WDT_CYCLES-1 and wins over a simultaneous expiry. Otherwise decrement. Fault and expiry in the same cycle → TRIPPED with both recorded.
- `fault_latched` ORs in the synchronised faults every cycle in all states. It is cleared only on an accepted clear; a fault in that same cycle means the clear is not accepted.
- `heartbeat` is ignored outside RUN.
- Counter widths are `$clog2` of their parameter. There is no wrap-around: each counter only decrements from a loaded value to 0.

## Timing
- Reset values: state SAFE, `shutdown`=1, `fault_latched`=0, `wdt_tripped`=0, `clear_ack`=0, `clear_nack`=0, synchronisers and counters 0.
- Reset asserted mid-operation returns to SAFE immediately (asynchronous), and `shutdown`=1.
- Fault latency: `fault_in` high at edge k → `shutdown` high after edge k+2. Pulses shorter than one clock period may be missed.
- Clear latency: `clear_req` accepted at edge k → `shutdown` low, and `clear_ack` high, after edge k+HOLDOFF_CYCLES.
- Watchdog: RUN entered at edge r with no heartbeat → TRIPPED after edge r+WDT_CYCLES. A `heartbeat` sampled at edge h pushes expiry to edge h+WDT_CYCLES.
- All outputs are registered. The ack/nack pulses last exactly one cycle, coincident with the state change or rejection.

## Configuration
- `MDA_SHUTDOWN_WDT_EN` defined: the watchdog counter and expiry logic are present, as described above.
- Not defined: no watchdog counter. `heartbeat` is ignored, `wdt_tripped` is tied 0, and RUN exits only on a fault or reset.

## Test plan
Parameters: NUM_FAULTS=2, HOLDOFF_CYCLES=4, WDT_CYCLES=10, with MDA_SHUTDOWN_WDT_EN defined.
- Release reset with no clear → `shutdown`=1, `state`=00, all flags 0 for 20 cycles.
- `clear_req` at edge k, faults low → `state`=11 after k; `shutdown`=0, `state`=01 and a one-cycle `clear_ack` after edge k+4.
- In RUN, `fault_in`=2'b10 at edge k → `shutdown`=1 and `state`=10 after k+2; `fault_latched`=2'b10. A `clear_req` while the fault is held → `clear_nack` pulse and no state change.
- In RUN, no heartbeat → trip exactly 10 edges after RUN entry, with `wdt_tripped`=1. A `heartbeat` on the expiry edge → no trip, and the next expiry is 10 edges later.
- `fault_in`=2'b01 pulsed during HOLDOFF → TRIPPED, `clear_nack` pulse, `fault_latched`=2'b01, `shutdown` stays 1.
- Deassert `reset_n` mid-RUN → `shutdown`=1 and `state`=00 asynchronously; a subsequent clear needs the full 4-cycle hold-off.

Source files
------------

// File: rtl/mda_shutdown_controller.sv
// Supervisory shutdown controller: synchronised fault latching, gated re-enable via clear + hold-off.
// Define MDA_SHUTDOWN_WDT_EN to include the software heartbeat watchdog.
module mda_shutdown_controller #(
    parameter int NUM_FAULTS     = 2,
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int WDT_CYCLES     = 50000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FAULTS-1:0] fault_in,
    input  logic                  heartbeat,
    input  logic                  clear_req,
    output logic                  shutdown,
    output logic [NUM_FAULTS-1:0] fault_latched,
    output logic                  wdt_tripped,
    output logic [1:0]            state,
    output logic                  clear_ack,
    output logic                  clear_nack
);
    typedef enum logic [1:0] {
        ST_SAFE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_TRIPPED = 2'b10,
        ST_HOLDOFF = 2'b11
    } state_t;

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

    logic [NUM_FAULTS-1:0] r_sync1, r_sync2;
    logic [NUM_FAULTS-1:0] r_latched, w_latched_next;
    logic [HOLD_W-1:0]     r_hold, w_hold_next;
    state_t                r_state, w_state_next;
    logic                  r_shutdown, r_ack, r_nack;
    logic                  w_ack_next, w_nack_next;
    logic                  w_fault;

    assign w_fault = |r_sync2;

`ifdef MDA_SHUTDOWN_WDT_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt, w_wdt_next;
    logic             r_wdt_tripped, w_wdt_tripped_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdt         <= '0;
            r_wdt_tripped <= 1'b0;
        end else begin
            r_wdt         <= w_wdt_next;
            r_wdt_tripped <= w_wdt_tripped_next;
        end
    end

    assign wdt_tripped = r_wdt_tripped;
`else
    logic w_unused_heartbeat;
    assign w_unused_heartbeat = heartbeat;
    assign wdt_tripped        = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold;
        w_latched_next = r_latched | r_sync2;
        w_ack_next     = 1'b0;
        w_nack_next    = 1'b0;
`ifdef MDA_SHUTDOWN_WDT_EN
        w_wdt_next         = r_wdt;
        w_wdt_tripped_next = r_wdt_tripped;
`endif
        case (r_state)
            ST_SAFE, ST_TRIPPED: begin
                // A live fault always overrides a clear request.
                if (clear_req) begin
                    if (w_fault) begin
                        w_nack_next = 1'b1;
                    end else begin
                        w_state_next   = ST_HOLDOFF;
                        w_hold_next    = HOLD_LOAD;
                        w_latched_next = '0;
`ifdef MDA_SHUTDOWN_WDT_EN
                        w_wdt_tripped_next = 1'b0;
`endif
                    end
                end
            end
            ST_HOLDOFF: begin
                if (w_fault) begin
                    w_state_next = ST_TRIPPED;
                    w_nack_next  = 1'b1;
                end else if (r_hold == '0) begin
                    w_state_next = ST_RUN;
                    w_ack_next   = 1'b1;
`ifdef MDA_SHUTDOWN_WDT_EN
                    w_wdt_next = WDT_LOAD;
`endif
                end else begin
                    w_hold_next = r_hold - HOLD_W'(1);
                end
            end
            ST_RUN: begin
`ifdef MDA_SHUTDOWN_WDT_EN
                // Heartbeat beats a simultaneous expiry; a fault records a coincident expiry too.
                if (w_fault) begin
                    w_state_next = ST_TRIPPED;
                    if (r_wdt == '0 && !heartbeat) w_wdt_tripped_next = 1'b1;
                end else if (heartbeat) begin
                    w_wdt_next = WDT_LOAD;
                end else if (r_wdt == '0) begin
                    w_state_next       = ST_TRIPPED;
                    w_wdt_tripped_next = 1'b1;
                end else begin
                    w_wdt_next = r_wdt - WDT_W'(1);
                end
`else
                if (w_fault) w_state_next = ST_TRIPPED;
`endif
            end
            default: w_state_next = ST_SAFE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_latched  <= '0;
            r_hold     <= '0;
            r_state    <= ST_SAFE;
            r_shutdown <= 1'b1;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_sync1    <= fault_in;
            r_sync2    <= r_sync1;
            r_latched  <= w_latched_next;
            r_hold     <= w_hold_next;
            r_state    <= w_state_next;
            r_shutdown <= (w_state_next != ST_RUN);
            r_ack      <= w_ack_next;
            r_nack     <= w_nack_next;
        end
    end

    assign shutdown      = r_shutdown;
    assign fault_latched = r_latched;
    assign state         = r_state;
    assign clear_ack     = r_ack;
    assign clear_nack    = r_nack;
endmodule
